// File: rtl/sdram_sim_mp.sv
// Behavioural multi-port SDRAM model: NBP time-sliced byte ports plus one toggle-handshake 16-bit word port.
// Define SDRAM_SIM_REFRESH_EN to emulate periodic refresh windows that stall both sides (busy high).
module sdram_sim_mp #(
    parameter int NBP            = 3,
    parameter int BYTE_AW        = 21,
    parameter int WORD_AW        = 20,
    parameter int REFRESH_PERIOD = 256,
    parameter int REFRESH_LEN    = 4
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   clkref,
    output logic                   busy,
    input  logic [NBP*BYTE_AW-1:0] b_addr,
    input  logic [NBP-1:0]         b_we,
    input  logic [NBP-1:0]         b_oe,
    input  logic [NBP*8-1:0]       b_din,
    output logic [NBP*8-1:0]       b_dout,
    input  logic [WORD_AW-1:0]     w_addr,
    input  logic [15:0]            w_din,
    input  logic [1:0]             w_ds,
    input  logic                   w_we,
    input  logic                   w_req,
    output logic                   w_ack,
    output logic [15:0]            w_dout
);

    logic [7:0]  bmem [0:(1<<BYTE_AW)-1];
    logic [15:0] wmem [0:(1<<WORD_AW)-1];

    logic               phase_q, phase_d;
    logic               clkref_q;
    logic [NBP*8-1:0]   b_dout_q, b_dout_d;
    logic [15:0]        w_dout_q, w_dout_d;
    logic               brd_q;
    logic [1:0]         bport_q;
    logic [BYTE_AW-1:0] baddr_q;
    logic               wreq_q, wack_q, wpend_q, wrd_q;
    logic [WORD_AW-1:0] waddr_q;

    logic               gnt_vld, gnt_wr;
    logic [1:0]         gnt_idx;
    logic [BYTE_AW-1:0] gnt_addr;
    logic [7:0]         gnt_din;
    logic               new_req, serve;

`ifdef SDRAM_SIM_REFRESH_EN
    localparam int CW = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;
    localparam logic [CW-1:0] REF_LAST  = CW'(REFRESH_PERIOD - 1);
    localparam logic [CW-1:0] REF_START = CW'(REFRESH_PERIOD - REFRESH_LEN);

    logic [CW-1:0] ref_cnt_q, ref_cnt_d;
    logic          busy_q, busy_d;

    // busy is registered so every consumer sees the same window edges.
    always_comb begin
        ref_cnt_d = (ref_cnt_q == REF_LAST) ? '0 : ref_cnt_q + CW'(1);
        busy_d    = (ref_cnt_d >= REF_START);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ref_cnt_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            ref_cnt_q <= ref_cnt_d;
            busy_q    <= busy_d;
        end
    end

    assign busy = busy_q;
`else
    logic unused_refresh_cfg;
    assign unused_refresh_cfg = ^{REFRESH_PERIOD, REFRESH_LEN};
    assign busy = 1'b0;
`endif

    // Byte slot arbitration: lowest index wins; losers must hold their request.
    always_comb begin
        phase_d = ~phase_q;
        if (clkref && !clkref_q) phase_d = 1'b0;

        gnt_vld  = 1'b0;
        gnt_wr   = 1'b0;
        gnt_idx  = '0;
        gnt_addr = '0;
        gnt_din  = '0;
        if (phase_q && !busy) begin
            for (int i = NBP - 1; i >= 0; i--) begin
                if (b_we[i] || b_oe[i]) begin
                    gnt_vld  = 1'b1;
                    gnt_wr   = b_we[i];
                    gnt_idx  = 2'(i);
                    gnt_addr = b_addr[i*BYTE_AW +: BYTE_AW];
                    gnt_din  = b_din[i*8 +: 8];
                end
            end
        end
    end

    always_comb begin
        b_dout_d = b_dout_q;
        if (brd_q) b_dout_d[bport_q*8 +: 8] = bmem[baddr_q];
        w_dout_d = w_dout_q;
        if (wrd_q) w_dout_d = wmem[waddr_q];
        new_req = !wpend_q && (w_req != wreq_q);
        serve   = wpend_q && !phase_q && !busy;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            phase_q  <= 1'b0;
            b_dout_q <= '0;
            w_dout_q <= '0;
            brd_q    <= 1'b0;
            bport_q  <= '0;
            baddr_q  <= '0;
            wreq_q   <= w_req;
            wack_q   <= w_req;
            wpend_q  <= 1'b0;
            wrd_q    <= 1'b0;
            waddr_q  <= '0;
        end else begin
            phase_q  <= phase_d;
            b_dout_q <= b_dout_d;
            w_dout_q <= w_dout_d;
            brd_q    <= gnt_vld && !gnt_wr;
            bport_q  <= gnt_idx;
            baddr_q  <= gnt_addr;
            wrd_q    <= serve && !w_we;
            waddr_q  <= w_addr;
            if (new_req) begin
                wreq_q  <= w_req;
                wpend_q <= 1'b1;
            end
            if (serve) begin
                wpend_q <= 1'b0;
                wack_q  <= wreq_q;
            end
        end
    end

    // Memories are never reset; writes are suppressed while resetn is low.
    always_ff @(posedge clk) begin
        clkref_q <= clkref;
        if (resetn && gnt_vld && gnt_wr) bmem[gnt_addr] <= gnt_din;
        if (resetn && serve && w_we) begin
            if (w_ds[1]) wmem[w_addr][15:8] <= w_din[15:8];
            if (w_ds[0]) wmem[w_addr][7:0]  <= w_din[7:0];
        end
    end

    assign b_dout = b_dout_q;
    assign w_dout = w_dout_q;
    assign w_ack  = wack_q;

endmodule

// File: tb/tb_sdram_sim_mp.sv
// Directed bench for sdram_sim_mp: vector table for byte/word traffic plus timing sequences.
`timescale 1ns/1ps
module tb_sdram_sim_mp;
  localparam int NBP = 3;
  localparam int BYTE_AW = 21;
  localparam int WORD_AW = 20;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic clkref = 1'b0;
  logic busy;
  logic [NBP*BYTE_AW-1:0] b_addr = '0;
  logic [NBP-1:0] b_we = '0;
  logic [NBP-1:0] b_oe = '0;
  logic [NBP*8-1:0] b_din = '0;
  logic [NBP*8-1:0] b_dout;
  logic [WORD_AW-1:0] w_addr = '0;
  logic [15:0] w_din = '0;
  logic [1:0] w_ds = '0;
  logic w_we = 1'b0;
  logic w_req = 1'b0;
  logic w_ack;
  logic [15:0] w_dout;

  int tests_run = 0;
  int tests_failed = 0;
  logic [NBP*8-1:0] exp_bdout = '0;
  logic [15:0] exp_wdout = '0;
  logic ph_m = 1'b0;
  logic ck_m = 1'b0;
  logic ack_old;

  sdram_sim_mp #(
    .NBP(NBP), .BYTE_AW(BYTE_AW), .WORD_AW(WORD_AW),
    .REFRESH_PERIOD(16), .REFRESH_LEN(4)
  ) dut (
    .clk(clk), .resetn(resetn), .clkref(clkref), .busy(busy),
    .b_addr(b_addr), .b_we(b_we), .b_oe(b_oe), .b_din(b_din), .b_dout(b_dout),
    .w_addr(w_addr), .w_din(w_din), .w_ds(w_ds), .w_we(w_we),
    .w_req(w_req), .w_ack(w_ack), .w_dout(w_dout)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // Slot tracker: the phase the next rising edge will see.
  always @(posedge clk) begin
    ck_m <= clkref;
    if (!resetn) ph_m <= 1'b0;
    else if (clkref && !ck_m) ph_m <= 1'b0;
    else ph_m <= ~ph_m;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic do_reset(input logic req_val);
    @(negedge clk);
    resetn = 1'b0;
    b_we = '0;
    b_oe = '0;
    w_req = req_val;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    exp_bdout = '0;
    exp_wdout = '0;
  endtask

  task automatic wait_slot(input logic ph);
    int n = 0;
    while (!(ph_m == ph && busy == 1'b0) && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (n >= 64) check("slot_timeout", 32'd1, 32'd0);
  endtask

  task automatic byte_op(input int port, input logic we, input logic oe, input logic [23:0] addr,
                         input logic [7:0] din, input logic [7:0] exp_rd, input string name);
    wait_slot(1'b1);
    b_addr[port*BYTE_AW +: BYTE_AW] = addr[BYTE_AW-1:0];
    b_din[port*8 +: 8] = din;
    b_we[port] = we;
    b_oe[port] = oe;
    @(negedge clk);
    b_we = '0;
    b_oe = '0;
    check({name, "_hold"}, 32'(b_dout), 32'(exp_bdout));
    @(negedge clk);
    if (oe && !we) exp_bdout[port*8 +: 8] = exp_rd;
    check(name, 32'(b_dout), 32'(exp_bdout));
  endtask

  task automatic word_op(input logic we, input logic [19:0] addr, input logic [15:0] din,
                         input logic [1:0] ds, input logic [15:0] exp_rd, input string name);
    int n = 0;
    w_we = we;
    w_addr = addr;
    w_din = din;
    w_ds = ds;
    w_req = ~w_req;
    do begin
      @(negedge clk);
      n++;
    end while (w_ack !== w_req && n < 64);
    check({name, "_ack"}, 32'(w_ack), 32'(w_req));
    @(negedge clk);
    if (!we) exp_wdout = exp_rd;
    check(name, 32'(w_dout), 32'(exp_wdout));
    check({name, "_ack_once"}, 32'(w_ack), 32'(w_req));
  endtask

  // kind: 0 byte wr, 1 byte rd, 2 byte wr+rd same port, 3 word wr, 4 word rd
  typedef struct {
    int kind;
    int port;
    logic [23:0] addr;
    logic [15:0] data;
    logic [1:0] ds;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[22];

  initial begin
    vecs[0]  = '{0, 1, 24'h001234, 16'h005A, 2'b00, 16'h0000};
    vecs[1]  = '{0, 0, 24'h000010, 16'h0011, 2'b00, 16'h0000};
    vecs[2]  = '{0, 2, 24'h000020, 16'h0022, 2'b00, 16'h0000};
    vecs[3]  = '{0, 0, 24'h1FFFFF, 16'h00A5, 2'b00, 16'h0000};
    vecs[4]  = '{1, 1, 24'h001234, 16'h0000, 2'b00, 16'h005A};
    vecs[5]  = '{1, 0, 24'h1FFFFF, 16'h0000, 2'b00, 16'h00A5};
    vecs[6]  = '{1, 2, 24'h000020, 16'h0000, 2'b00, 16'h0022};
    vecs[7]  = '{2, 2, 24'h000020, 16'h0033, 2'b00, 16'h0000};
    vecs[8]  = '{1, 2, 24'h000020, 16'h0000, 2'b00, 16'h0033};
    vecs[9]  = '{1, 0, 24'h000010, 16'h0000, 2'b00, 16'h0011};
    vecs[10] = '{3, 0, 24'h000100, 16'hBEEF, 2'b11, 16'h0000};
    vecs[11] = '{3, 0, 24'h000100, 16'h12AB, 2'b10, 16'h0000};
    vecs[12] = '{4, 0, 24'h000100, 16'h0000, 2'b00, 16'h12EF};
    vecs[13] = '{3, 0, 24'h000100, 16'h0000, 2'b00, 16'h0000};
    vecs[14] = '{4, 0, 24'h000100, 16'h0000, 2'b00, 16'h12EF};
    vecs[15] = '{3, 0, 24'h000100, 16'h9934, 2'b01, 16'h0000};
    vecs[16] = '{4, 0, 24'h000100, 16'h0000, 2'b00, 16'h1234};
    vecs[17] = '{3, 0, 24'h0FFFFF, 16'hCAFE, 2'b11, 16'h0000};
    vecs[18] = '{3, 0, 24'h000010, 16'h7777, 2'b11, 16'h0000};
    vecs[19] = '{4, 0, 24'h0FFFFF, 16'h0000, 2'b00, 16'hCAFE};
    vecs[20] = '{1, 1, 24'h000010, 16'h0000, 2'b00, 16'h0011};
    vecs[21] = '{4, 0, 24'h000010, 16'h0000, 2'b00, 16'h7777};

    do_reset(1'b0);
    check("rst_bdout", 32'(b_dout), 32'h0);
    check("rst_wdout", 32'(w_dout), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_ack", 32'(w_ack), 32'(w_req));

    for (int i = 0; i < 22; i++) begin
      case (vecs[i].kind)
        0: byte_op(vecs[i].port, 1'b1, 1'b0, vecs[i].addr, vecs[i].data[7:0], 8'h00, $sformatf("v%0d_bwr", i));
        1: byte_op(vecs[i].port, 1'b0, 1'b1, vecs[i].addr, 8'h00, vecs[i].exp[7:0], $sformatf("v%0d_brd", i));
        2: byte_op(vecs[i].port, 1'b1, 1'b1, vecs[i].addr, vecs[i].data[7:0], 8'h00, $sformatf("v%0d_bwo", i));
        3: word_op(1'b1, vecs[i].addr[19:0], vecs[i].data, vecs[i].ds, 16'h0000, $sformatf("v%0d_wwr", i));
        default: word_op(1'b0, vecs[i].addr[19:0], 16'h0000, 2'b00, vecs[i].exp, $sformatf("v%0d_wrd", i));
      endcase
    end

    // Memory survives reset.
    do_reset(w_req);
    byte_op(1, 1'b0, 1'b1, 24'h001234, 8'h00, 8'h5A, "keep_after_rst");

    // Priority: ports 0 and 2 in one slot, port 2 served in the following slot.
    do_reset(w_req);
    wait_slot(1'b1);
    b_addr[0 +: BYTE_AW] = 21'h000010;
    b_addr[2*BYTE_AW +: BYTE_AW] = 21'h000020;
    b_oe = 3'b101;
    @(negedge clk);
    check("prio_g1", 32'(b_dout), 32'h000000);
    @(negedge clk);
    check("prio_p0", 32'(b_dout), 32'h000011);
    b_oe = 3'b100;
    @(negedge clk);
    check("prio_g2", 32'(b_dout), 32'h000011);
    @(negedge clk);
    check("prio_p2", 32'(b_dout), 32'h330011);
    b_oe = '0;

    // Realign: clkref rise while phase is 0 delays the next grant by one cycle.
    do_reset(w_req);
    clkref = 1'b1;
    b_addr[0 +: BYTE_AW] = 21'h1FFFFF;
    b_oe = 3'b001;
    @(negedge clk);
    clkref = 1'b0;
    check("align_x0", 32'(b_dout), 32'h0);
    @(negedge clk);
    check("align_x1", 32'(b_dout), 32'h0);
    @(negedge clk);
    check("align_x2", 32'(b_dout), 32'h0);
    @(negedge clk);
    check("align_x3", 32'(b_dout), 32'h0000A5);
    b_oe = '0;

    // Word handshake timing: detect, then serve on the next phase-0 edge.
    do_reset(1'b0);
    w_we = 1'b0;
    w_addr = 20'h00100;
    w_req = 1'b1;
    @(negedge clk);
    check("wt_f1_ack", 32'(w_ack), 32'h0);
    @(negedge clk);
    check("wt_f2_ack", 32'(w_ack), 32'h0);
    @(negedge clk);
    check("wt_f3_ack", 32'(w_ack), 32'h1);
    check("wt_f3_dout", 32'(w_dout), 32'h0);
    @(negedge clk);
    check("wt_f4_dout", 32'(w_dout), 32'h1234);

    // Reset with a pending word request: dropped, ack follows w_req, memory intact.
    do_reset(1'b0);
    w_we = 1'b1;
    w_addr = 20'h00100;
    w_din = 16'hDEAD;
    w_ds = 2'b11;
    w_req = 1'b1;
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    check("rstp_ack", 32'(w_ack), 32'h1);
    @(negedge clk);
    resetn = 1'b1;
    exp_wdout = '0;
    exp_bdout = '0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("rstp_ack_hold%0d", k), 32'(w_ack), 32'h1);
    end
    word_op(1'b0, 20'h00100, 16'h0000, 2'b00, 16'h1234, "rstp_mem");

`ifdef SDRAM_SIM_REFRESH_EN
    // Refresh window: requests raised at busy rise wait until busy falls.
    begin
      int n = 0;
      do_reset(w_req);
      while (busy !== 1'b1 && n < 40) begin
        @(negedge clk);
        n++;
      end
      check("ref_busy_rise", 32'(busy), 32'h1);
      b_addr[0 +: BYTE_AW] = 21'h000010;
      b_oe = 3'b001;
      w_we = 1'b0;
      w_addr = 20'hFFFFF;
      ack_old = w_ack;
      w_req = ~w_req;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        check($sformatf("ref_ack_held%0d", k), 32'(w_ack), 32'(ack_old));
        check($sformatf("ref_no_gnt%0d", k), 32'(b_dout), 32'h0);
      end
      check("ref_busy_fall", 32'(busy), 32'h0);
      @(negedge clk);
      check("ref_ack", 32'(w_ack), 32'(w_req));
      check("ref_bdout_e17", 32'(b_dout), 32'h0);
      @(negedge clk);
      check("ref_wdout", 32'(w_dout), 32'hCAFE);
      check("ref_bdout_e18", 32'(b_dout), 32'h0);
      @(negedge clk);
      check("ref_bdout", 32'(b_dout), 32'h000011);
      b_oe = '0;
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
